jtag_bsr_chain: RTL and testbench
=================================

# jtag_bsr_chain

Boundary-scan register (BSR) chain sitting directly downstream of the JTAG TAP/test-logic block. It consumes that block's BSR control outputs (`bsr_tdi`, `bsr_clk`, `bsr_shift`, `bsr_update`, `bsr_mode`) and returns serial data on `bsr_tdo`. It holds one capture/shift/update cell per input pin, one per output pin, and one output-enable control cell. In test mode it overrides the pin and core-side signals with the update-register contents.

## Interface
- `WIDTH`, default 8: number of input cells; also the number of output cells.
- Derived chain length: L = 2*WIDTH+1.
- `clk` in 1: TCK. All state is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low. It is the TAP trst.
- `bsr_tdi` in 1: serial data in; enters cell L-1.
- `bsr_clk` in 1: cell clock-enable from the TAP; sampled synchronously. It is not a clock.
- `bsr_shift` in 1: with `bsr_clk`, 1 = shift and 0 = capture.
- `bsr_update` in 1: loads the update register from the shift register.
- `bsr_mode` in 1: 0 = functional passthrough; 1 = test drive from the update register.
- `bsr_tdo` out 1: serial data out, equal to cell 0.
- `pin_in` in WIDTH: pad input values.
- `core_in` out WIDTH: values delivered to the core.
- `core_out` in WIDTH: core output values.
- `core_oe` in 1: core output enable.
- `pin_out` out WIDTH: values driven to the pads.
- `pin_oe` out 1: pad output enable.

## Operation
Cell map, for both `sr` (shift register) and `ur` (update register):
- bits [WIDTH-1:0] are input cells;
- bits [2W-1:W] are output cells;
- bit [2W] is the OE cell.

Per rising `clk`, when `rst_n`=1:
- `bsr_clk`=1 and `bsr_shift`=0 (capture):
  - `sr[W-1:0]` <= `pin_in`
  - `sr[2W-1:W]` <= `core_out`
  - `sr[2W]` <= `core_oe`
- `bsr_clk`=1 and `bsr_shift`=1 (shift): `sr` <= {`bsr_tdi`, `sr[L-1:1]`}. LSB shifts out first.
- `bsr_clk`=0: `sr` holds, regardless of `bsr_shift`.
- `bsr_update`=1: `ur` <= `sr` (the pre-edge value). Otherwise `ur` holds.

Simultaneous events:
- Update together with shift or capture in the same cycle: `ur` takes the old `sr`, and `sr` advances or captures normally.

Combinational outputs:
- `bsr_tdo` = `sr[0]`.
- `bsr_mode`=0: `pin_out`=`core_out`, `pin_oe`=`core_oe`, `core_in`=`pin_in`.
- `bsr_mode`=1: `pin_out`=`ur[2W-1:W]`, `pin_oe`=`ur[2W]`, `core_in`=`ur[W-1:0]`.
- `bsr_mode` changes take effect combinationally in the same cycle and never modify `sr` or `ur`.

Reset (asynchronous, at any time, including mid-shift):
- `sr`=0 and `ur`=0 immediately.
- Hence `bsr_tdo`=0. With `bsr_mode`=1, `pin_out`=0, `pin_oe`=0 and `core_in`=0.
- A partially shifted pattern is discarded.

No internal FSM: sequencing is owned by the TAP. This block is a pure datapath of enables.

## Timing
- Capture: data sampled at edge N is visible on `bsr_tdo` (cell 0 = `pin_in[0]`) after edge N.
- Shift: the bit on `bsr_tdi` at edge N reaches `bsr_tdo` after L shift-enabled edges. With WIDTH=8 that is 17 edges.
- Update: `ur` changes at the update edge. Test-mode outputs reflect it in the same cycle after that edge.
- `bsr_tdo` is registered-output only, with no extra pipeline stage. Any negedge retiming belongs to the TAP.

## Test plan
All scenarios use WIDTH=8.

1. **Reset values.** Assert `rst_n`=0 mid-cycle with `sr` nonzero, `bsr_mode`=1 → `bsr_tdo`=0, `pin_out`=0x00, `pin_oe`=0, `core_in`=0x00 without waiting for a clock edge.
2. **Capture and shift out.** Set `pin_in`=0xA5, `core_out`=0x3C, `core_oe`=1. Apply one capture, then 17 shifts → `bsr_tdo` sequence is 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1.
3. **Shift in, update, test drive.** Shift in 17 bits encoding `ur`=0x1_C3_5A ({oe=1, out=0xC3, in=0x5A}), pulse `bsr_update`, set `bsr_mode`=1 → `pin_out`=0xC3, `pin_oe`=1, `core_in`=0x5A. Then set `bsr_mode`=0 → outputs equal `core_out`/`core_oe`/`pin_in`.
4. **Hold.** Drive `bsr_clk`=0 with `bsr_shift`=1 while toggling `bsr_tdi` for 10 cycles → `sr` and `bsr_tdo` unchanged.
5. **Simultaneous update and shift.** With `sr`=0x1FFFF, assert `bsr_update`=1, `bsr_clk`=1, `bsr_shift`=1 and `bsr_tdi`=0 in one cycle → `ur`=0x1FFFF and `sr`=0x0FFFF.
6. **Reset mid-shift.** After 5 of 17 shifts, pulse `rst_n` low → `sr`=0 and `ur`=0. A subsequent full shift of 17 zeros yields `bsr_tdo`=0 throughout.

Source files
------------

// File: rtl/jtag_bsr_chain_if.sv
// Boundary-scan chain bus: TAP-side cell controls plus the pin/core signal pairs
// that the chain sits between.
interface jtag_bsr_chain_if #(
  parameter int unsigned WIDTH = 8
);

  // TAP-side cell controls and serial return
  logic             bsr_tdi;
  logic             bsr_clk;
  logic             bsr_shift;
  logic             bsr_update;
  logic             bsr_mode;
  logic             bsr_tdo;

  // Pad and core sides of the boundary
  logic [WIDTH-1:0] pin_in;
  logic [WIDTH-1:0] core_in;
  logic [WIDTH-1:0] core_out;
  logic             core_oe;
  logic [WIDTH-1:0] pin_out;
  logic             pin_oe;

  // Driver of controls, pads and core outputs (TAP + surroundings)
  modport master (
    output bsr_tdi, bsr_clk, bsr_shift, bsr_update, bsr_mode,
    output pin_in, core_out, core_oe,
    input  bsr_tdo, core_in, pin_out, pin_oe
  );

  // The boundary-scan chain itself
  modport slave (
    input  bsr_tdi, bsr_clk, bsr_shift, bsr_update, bsr_mode,
    input  pin_in, core_out, core_oe,
    output bsr_tdo, core_in, pin_out, pin_oe
  );

endinterface

// File: rtl/jtag_bsr_chain.sv
// Boundary-scan register chain: input cells, output cells and one OE cell, each
// with capture/shift and update stages; test mode drives pins/core from update.
module jtag_bsr_chain #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  jtag_bsr_chain_if.slave       bus
);

  localparam int unsigned LEN    = 2 * WIDTH + 1;
  localparam int unsigned OE_BIT = 2 * WIDTH;

  logic [LEN-1:0] sr_q;
  logic [LEN-1:0] sr_d;
  logic [LEN-1:0] ur_q;
  logic [LEN-1:0] ur_d;

  // Cell enables: capture/shift on sr, update copies the pre-edge sr into ur
  always_comb begin
    sr_d = sr_q;
    ur_d = ur_q;
    if (bus.bsr_clk) begin
      if (bus.bsr_shift) begin
        sr_d = {bus.bsr_tdi, sr_q[LEN-1:1]};
      end else begin
        sr_d = {bus.core_oe, bus.core_out, bus.pin_in};
      end
    end
    if (bus.bsr_update) begin
      ur_d = sr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
      ur_q <= '0;
    end else begin
      sr_q <= sr_d;
      ur_q <= ur_d;
    end
  end

  // Boundary muxes are combinational so a mode change acts in the same cycle
  assign bus.bsr_tdo = sr_q[0];
  assign bus.pin_out = bus.bsr_mode ? ur_q[OE_BIT-1:WIDTH] : bus.core_out;
  assign bus.pin_oe  = bus.bsr_mode ? ur_q[OE_BIT]         : bus.core_oe;
  assign bus.core_in = bus.bsr_mode ? ur_q[WIDTH-1:0]      : bus.pin_in;

endmodule

// File: tb/tb_jtag_bsr_chain.sv
// Directed bench for jtag_bsr_chain (WIDTH=8, chain length 17).
module tb_jtag_bsr_chain;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LEN   = 2 * WIDTH + 1;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  jtag_bsr_chain_if #(.WIDTH(WIDTH)) bus ();

  jtag_bsr_chain #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given controls; inputs settle 1 unit after the edge
  task automatic cyc(input logic c, input logic s, input logic u, input logic t);
    bus.bsr_clk    = c;
    bus.bsr_shift  = s;
    bus.bsr_update = u;
    bus.bsr_tdi    = t;
    @(posedge clk);
    #1;
    bus.bsr_clk    = 1'b0;
    bus.bsr_shift  = 1'b0;
    bus.bsr_update = 1'b0;
    bus.bsr_tdi    = 1'b0;
  endtask

  task automatic shift_in(input logic [LEN-1:0] v);
    for (int i = 0; i < int'(LEN); i++) cyc(1'b1, 1'b1, 1'b0, v[i]);
  endtask

  task automatic shift_out(output logic [LEN-1:0] w);
    for (int i = 0; i < int'(LEN); i++) begin
      w[i] = bus.bsr_tdo;
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
    end
  endtask

  logic [LEN-1:0] word;

  initial begin
    errors = 0;
    checks = 0;
    rst_n          = 1'b0;
    bus.bsr_tdi    = 1'b0;
    bus.bsr_clk    = 1'b0;
    bus.bsr_shift  = 1'b0;
    bus.bsr_update = 1'b0;
    bus.bsr_mode   = 1'b1;
    bus.pin_in     = 8'h00;
    bus.core_out   = 8'h00;
    bus.core_oe    = 1'b0;
    #12;
    check("por_tdo",     32'(bus.bsr_tdo), 32'h0);
    check("por_pin_out", 32'(bus.pin_out), 32'h0);
    rst_n = 1'b1;
    bus.bsr_mode = 1'b0;
    @(posedge clk);
    #1;

    // Capture then shift out: pins LSB first, then core_out, then OE
    bus.pin_in   = 8'hA5;
    bus.core_out = 8'h3C;
    bus.core_oe  = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("cap_tdo0", 32'(bus.bsr_tdo), 32'h1);
    shift_out(word);
    check("cap_shift_word", 32'(word), 32'h13CA5);
    check("cap_tdo_after", 32'(bus.bsr_tdo), 32'h0);

    // Shift in {oe=1,out=C3,in=5A}, update, drive in test mode
    shift_in(17'h1C35A);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    bus.bsr_mode = 1'b1;
    #1;
    check("tm_pin_out", 32'(bus.pin_out), 32'hC3);
    check("tm_pin_oe",  32'(bus.pin_oe),  32'h1);
    check("tm_core_in", 32'(bus.core_in), 32'h5A);
    bus.core_oe  = 1'b0;
    bus.bsr_mode = 1'b0;
    #1;
    check("fn_pin_out", 32'(bus.pin_out), 32'h3C);
    check("fn_pin_oe",  32'(bus.pin_oe),  32'h0);
    check("fn_core_in", 32'(bus.core_in), 32'hA5);

    // Hold: bsr_clk low ignores shift and tdi
    shift_in(17'h0B6D3);
    check("hold_tdo_pre", 32'(bus.bsr_tdo), 32'h1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 1'b0, i[0]);
      check("hold_tdo", 32'(bus.bsr_tdo), 32'h1);
    end
    shift_out(word);
    check("hold_word", 32'(word), 32'h0B6D3);

    // Update concurrent with shift: ur takes old sr
    shift_in(17'h1FFFF);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    bus.bsr_mode = 1'b1;
    #1;
    check("upsh_pin_out", 32'(bus.pin_out), 32'hFF);
    check("upsh_pin_oe",  32'(bus.pin_oe),  32'h1);
    check("upsh_core_in", 32'(bus.core_in), 32'hFF);
    shift_out(word);
    check("upsh_sr_word", 32'(word), 32'h0FFFF);

    // Asynchronous reset mid-cycle with sr and ur nonzero, test mode on
    shift_in(17'h1AAAB);
    check("rst_pre_tdo", 32'(bus.bsr_tdo), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_tdo",      32'(bus.bsr_tdo), 32'h0);
    check("rst_pin_out",  32'(bus.pin_out), 32'h0);
    check("rst_pin_oe",   32'(bus.pin_oe),  32'h0);
    check("rst_core_in",  32'(bus.core_in), 32'h0);
    #1 rst_n = 1'b1;

    // Reset mid-shift discards the partial pattern
    shift_in(17'h1FFFF);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
    check("mid_pre_oe", 32'(bus.pin_oe), 32'h1);
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    check("mid_pin_out", 32'(bus.pin_out), 32'h0);
    check("mid_pin_oe",  32'(bus.pin_oe),  32'h0);
    check("mid_core_in", 32'(bus.core_in), 32'h0);
    shift_out(word);
    check("mid_zero_word", 32'(word), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
